// File: rtl/cache_refill_ctrl.sv
// Refill/write-through sequencer for a 4-set direct-mapped cache with 4-word lines.
// Optional load hit/miss counters are built only when CACHE_PERF_CNT_EN is defined.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic                    hit,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    fill_en,
  output logic [ADDR_WIDTH-1:0]   fill_addr,
  output logic [4*DATA_WIDTH-1:0] fill_line,
  output logic                    inval_en,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:2]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic                    st_hit_reg, st_hit_next;
  logic [1:0]              cnt_reg, cnt_next;
  logic                    capture;

  // Byte offset never reaches memory or the cache array.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      st_hit_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      st_hit_reg <= st_hit_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    st_hit_next = st_hit_reg;
    cnt_next    = cnt_reg;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_en     = 1'b0;
    inval_en    = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        stall = cpu_req & (cpu_we | ~hit);
        if (cpu_req) begin
          if (cpu_we) begin
            addr_next   = cpu_addr[ADDR_WIDTH-1:2];
            wdata_next  = cpu_wdata;
            st_hit_next = hit;
            state_next  = STORE;
          end else if (!hit) begin
            addr_next  = cpu_addr[ADDR_WIDTH-1:2];
            cnt_next   = 2'd0;
            state_next = FETCH;
          end
        end
      end
      FETCH: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr_reg[ADDR_WIDTH-1:4], cnt_reg, 2'b00};
        if (mem_ack) begin
          capture  = 1'b1;
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        stall      = 1'b1;
        fill_en    = 1'b1;
        state_next = IDLE;
      end
      STORE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_reg, 2'b00};
        mem_wdata = wdata_reg;
        if (mem_ack) begin
          inval_en   = st_hit_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // fill_addr doubles as the set selector for inval_en during a store.
  assign fill_addr = {addr_reg[ADDR_WIDTH-1:4], 4'b0000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] word_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (capture && (cnt_reg == 2'(gi))) begin
          word_reg <= mem_rdata;
        end
      end
      assign fill_line[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
    end
  endgenerate

`ifdef CACHE_PERF_CNT_EN
  logic        load_hit, miss_start;
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  assign load_hit   = (state_reg == IDLE) & cpu_req & ~cpu_we & hit;
  assign miss_start = (state_reg == IDLE) & cpu_req & ~cpu_we & ~hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (load_hit && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (miss_start && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: random loads/stores against a line-level
// cache/memory reference model, with a cache-array and memory emulation around the DUT.
module tb_cache_refill_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req, cpu_we, hit;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          stall, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr, fill_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          fill_en, inval_en;
  logic [4*DW-1:0] fill_line;
  logic [31:0]   hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .hit(hit), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fill_en(fill_en), .fill_addr(fill_addr),
    .fill_line(fill_line), .inval_en(inval_en), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Cache array emulation: written by the DUT's strobes, drives hit.
  logic        arr_valid [4];
  logic [25:0] arr_tag   [4];
  assign hit = arr_valid[cpu_addr[5:4]] && (arr_tag[cpu_addr[5:4]] == cpu_addr[31:6]);

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) arr_valid[i] <= 1'b0;
    end else begin
      if (fill_en) begin
        arr_valid[fill_addr[5:4]] <= 1'b1;
        arr_tag[fill_addr[5:4]]   <= fill_addr[31:6];
      end
      if (inval_en) arr_valid[fill_addr[5:4]] <= 1'b0;
    end
  end

  // Main memory emulation with a programmable number of wait cycles per request.
  logic [31:0] mem_model [256];
  int wait_cfg = 0;
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && wcnt >= wait_cfg) begin
        mem_ack = 1'b1;
        if (mem_we) mem_model[mem_addr[9:2]] = mem_wdata;
        else mem_rdata = mem_model[mem_addr[9:2]];
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) wcnt++;
        else wcnt = 0;
      end
    end
  end

  // Reference model: what the cache and memory should contain, at transaction level.
  typedef struct { logic [31:0] addr; logic [31:0] data; logic inval; } st_exp_t;
  typedef struct { logic [31:0] addr; logic [127:0] line; } fill_exp_t;
  logic [31:0] ref_mem   [256];
  logic        ref_valid [4];
  logic [25:0] ref_tag   [4];
  int          stall_q [$];
  logic [31:0] rd_q [$];
  st_exp_t     st_q [$];
  fill_exp_t   fill_q [$];
  int exp_hits = 0;
  int exp_miss = 0;
  bit mon_en = 0;

  // Monitor: pops expectations whenever the DUT presents a result.
  initial begin
    int run;
    bit pend, prev_wait;
    logic [31:0] prev_addr;
    st_exp_t se;
    fill_exp_t fe;
    run = 0; pend = 0; prev_wait = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (stall) run++;
        if (cpu_req) pend = 1;
        if (!cpu_req && pend) begin
          if (stall_q.size() == 0) begin
            n_checks++; $display("FAIL stall_cycles: unexpected transaction end, got %0d", run);
          end else check("stall_cycles", 128'(run), 128'(stall_q.pop_front()));
          run = 0; pend = 0;
        end
        if (prev_wait && mem_req) check("mem_addr_stable", mem_addr, prev_addr);
        if (mem_req && !mem_we && mem_ack) begin
          if (rd_q.size() == 0) begin
            n_checks++; $display("FAIL read_addr: unexpected read of %0h, expected none", mem_addr);
          end else check("read_addr", mem_addr, rd_q.pop_front());
        end
        if (mem_req && mem_we && mem_ack) begin
          if (st_q.size() == 0) begin
            n_checks++; $display("FAIL store: unexpected write to %0h, expected none", mem_addr);
          end else begin
            se = st_q.pop_front();
            check("store_addr", mem_addr, se.addr);
            check("store_data", mem_wdata, se.data);
            check("store_inval", inval_en, se.inval);
            if (se.inval) check("inval_set", fill_addr[5:4], se.addr[5:4]);
          end
        end else if (inval_en) begin
          n_checks++; $display("FAIL stray_inval: got inval_en=1, expected 0");
        end
        if (fill_en) begin
          if (fill_q.size() == 0) begin
            n_checks++; $display("FAIL fill: unexpected fill at %0h, expected none", fill_addr);
          end else begin
            fe = fill_q.pop_front();
            check("fill_addr", fill_addr, fe.addr);
            check("fill_line", fill_line, fe.line);
          end
        end
        prev_wait = mem_req && !mem_ack;
        prev_addr = mem_addr;
      end
    end
  end

  int txn_id = 0;

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data, input int w);
    logic [1:0]   set;
    logic         rhit;
    logic [31:0]  base;
    logic [127:0] line;
    fill_exp_t    fe;
    st_exp_t      se;
    bit           done;
    set  = addr[5:4];
    rhit = ref_valid[set] && (ref_tag[set] == addr[31:6]);
    base = {addr[31:4], 4'b0000};
    if (!we) begin
      exp_hits++;
      if (rhit) stall_q.push_back(0);
      else begin
        stall_q.push_back(6 + 4 * w);
        for (int k = 0; k < 4; k++) begin
          rd_q.push_back(base + 32'(4 * k));
          line[32*k +: 32] = ref_mem[int'(base[9:2]) + k];
        end
        fe.addr = base; fe.line = line;
        fill_q.push_back(fe);
        ref_valid[set] = 1'b1;
        ref_tag[set] = addr[31:6];
        exp_miss++;
      end
    end else begin
      stall_q.push_back(2 + w);
      se.addr = {addr[31:2], 2'b00}; se.data = data; se.inval = rhit;
      st_q.push_back(se);
      ref_mem[addr[9:2]] = data;
      if (rhit) ref_valid[set] = 1'b0;
    end
    $display("txn %0d: %s addr=%08h data=%08h wait=%0d model_hit=%0d",
             txn_id, we ? "store" : "load ", addr, data, w, rhit);
    txn_id++;
    @(negedge clk);
    wait_cfg = w; cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      #2;
      if (!we && !stall) done = 1;
      else if (we && mem_req && mem_we && mem_ack) done = 1;
      if (!done) begin
        @(negedge clk);
        cpu_wdata = $urandom;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL txn_timeout: transaction %0d still stalled after 400 cycles", txn_id - 1);
      finish_run();
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  initial begin
    int acks, r;
    bit seen_fill;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    for (int i = 0; i < 4; i++) mem_model[64 + i] = 32'hA0 + 32'(i);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_model[i];
    for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_fill_en", fill_en, 1'b0);
    check("rst_inval_en", inval_en, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_fill_addr", fill_addr, 32'h0);
    check("rst_fill_line", fill_line, 128'h0);
    check("rst_hit_cnt", hit_cnt, 32'h0);
    check("rst_miss_cnt", miss_cnt, 32'h0);

    // Reset in the middle of a refill: the partial line must never be filled.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_cfg = 0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
    acks = 0;
    for (int c = 0; c < 50 && acks < 2; c++) begin
      #2;
      if (mem_req && mem_ack) acks++;
      if (acks < 2) @(negedge clk);
    end
    check("mid_refill_acks", 128'(acks), 128'(2));
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    #2;
    check("abort_stall", stall, 1'b0);
    check("abort_mem_req", mem_req, 1'b0);
    seen_fill = fill_en;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #2;
      if (fill_en) seen_fill = 1;
    end
    check("abort_no_fill", seen_fill, 1'b0);

    mon_en = 1;
    do_txn(1'b0, 32'h0000_0104, 32'h0, 0);
    do_txn(1'b0, 32'h0000_0200, 32'h0, 0);
    do_txn(1'b0, 32'h0000_0104, 32'h0, 3);
    do_txn(1'b0, 32'h0000_0020, 32'h0, 0);
    do_txn(1'b1, 32'h0000_0024, 32'hDEAD_BEEF, 0);
    do_txn(1'b1, 32'h0000_0024, 32'hDEAD_BEEF, 1);
    do_txn(1'b0, 32'h0000_0040, 32'h0, 0);

    // Five back-to-back load hits on a resident line.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    stall_q.push_back(0);
    exp_hits += 5;
    $display("txn %0d: load  addr=00000040 held 5 cycles", txn_id);
    txn_id++;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("hit_run_stall", stall, 1'b0);
      check("hit_run_mem_req", mem_req, 1'b0);
      @(negedge clk);
    end
    cpu_req = 1'b0;

    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 1023);
      do_txn(($urandom_range(0, 9) < 3), 32'(r), $urandom, $urandom_range(0, 2));
    end

    @(negedge clk);
    #3;
    check("stall_q_empty", 128'(stall_q.size()), 128'(0));
    check("rd_q_empty", 128'(rd_q.size()), 128'(0));
    check("st_q_empty", 128'(st_q.size()), 128'(0));
    check("fill_q_empty", 128'(fill_q.size()), 128'(0));
`ifdef CACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_miss));
`else
    check("hit_cnt", hit_cnt, 32'h0);
    check("miss_cnt", miss_cnt, 32'h0);
`endif
    finish_run();
  end

endmodule
